video_clk_enable_gen: RTL and testbench
=======================================

# video_clk_enable_gen

Multi-channel fractional clock-enable generator for the VGA/video subsystem. It runs entirely on the 50 MHz reference clock and produces per-channel single-cycle enable pulses at programmable fractional rates, for example 25 MHz and 33 MHz equivalents, using phase accumulators. It also provides a `locked` indication that drops and re-settles on every reconfiguration. Pixel pipelines use these enables instead of separate PLL output clocks, so all video logic stays in one clock domain.

## Interface
- `NUM_CH`, 3: number of enable channels (1–8).
- `ACC_W`, 16: accumulator and increment width (8–32). Rate of channel i = f_refclk × inc[i] / 2^ACC_W.
- `LOCK_CYCLES`, 1024: settle cycles before `locked` asserts (≥2).
- `refclk`  in  1: sole clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `cfg_valid`  in  1: configuration write request.
- `cfg_ready`  out  1: block can accept a configuration write.
- `cfg_ch`  in  3: target channel index.
- `cfg_inc`  in  ACC_W: new increment for `cfg_ch`.
- `cfg_phase`  in  ACC_W: new phase offset for `cfg_ch`.
- `ce_out`  out  NUM_CH: per-channel enable pulses, registered.
- `locked`  out  1: all channels are realigned and settled.

## Operation
- Per channel: registers `inc[i]`, `phase[i]`, `acc[i]`. Each cycle, sum = {1'b0,acc[i]} + inc[i] (ACC_W+1 bits).
  - `acc[i]` takes sum[ACC_W-1:0], wrapping mod 2^ACC_W.
  - `ce_out[i]` takes sum[ACC_W].
- inc = 0: the channel never pulses. inc = 2^(ACC_W-1): pulses every 2nd cycle. Maximum rate is inc = 2^ACC_W−1.
- FSM states: SETTLE, LOCKED, UPDATE.
  - Reset → SETTLE, settle counter = 0.
  - SETTLE: counter increments each cycle. When counter == LOCK_CYCLES−1 → LOCKED.
  - LOCKED: holds until a configuration write is accepted.
  - SETTLE or LOCKED with an accepted write → UPDATE.
  - UPDATE (exactly 1 cycle) → SETTLE with counter = 0.
- `cfg_ready` = 1 in SETTLE and LOCKED, 0 in UPDATE and during reset.
- A write is accepted on a rising edge with `cfg_valid` && `cfg_ready`. On that edge:
  - `inc[cfg_ch]` ← `cfg_inc`, `phase[cfg_ch]` ← `cfg_phase`.
  - `locked` ← 0; state ← UPDATE.
- In UPDATE: every `acc[i]` ← `phase[i]` (all channels realign together) and `ce_out` ← 0.
- A write with `cfg_ch` ≥ NUM_CH is accepted (handshake completes) but ignored: no register change, no UPDATE, `locked` unchanged.
- Accumulators and `ce_out` keep running during SETTLE. Consumers gate on `locked`.

## Timing
- Reset values:
  - `ce_out` = 0, `locked` = 0, `cfg_ready` = 0 while `rst_n` is low.
  - acc = 0, phase = 0, inc = 2^(ACC_W−1) for all channels.
- `cfg_ready` goes to 1 on the first rising edge after `rst_n` deasserts.
- Enable latency: `ce_out[i]` reflects the carry of the accumulation done on the previous edge (1-cycle registered).
- `locked` rises LOCK_CYCLES edges after reset release, or after the UPDATE cycle. It is high from the edge that leaves SETTLE.
- Configuration write to realignment: the accepting edge is followed by the UPDATE edge. The first new-rate accumulation happens on the edge after UPDATE, and the first possible pulse is visible 1 cycle later.
- `cfg_valid` held high in LOCKED: one write is accepted; the next can be accepted 2 edges later. Each accepted write restarts settling.
- Reset asserted mid-UPDATE or mid-SETTLE: all state returns immediately (asynchronously) to reset values, and any pending write is lost.

## Configuration
- `VIDEO_CLKEN_TOGGLE_EN`: when defined, adds output `clk_div [NUM_CH-1:0]`.
  - Per-channel toggle flop, reset 0, inverts on each cycle where `ce_out[i]` = 1.
  - Forced to 0 in UPDATE.
  - Gives a ~50%-duty square wave at half the enable rate for driving pins.
- When undefined, the port and flops are absent and behaviour is otherwise identical.

## Test plan
- Reset, defaults, ACC_W=16, LOCK_CYCLES=1024 → `ce_out` = 3'b111 every 2nd cycle; `locked` rises on edge 1024 after release.
- Write ch2 inc=0xA8F6, phase=0 → `locked` drops next edge; over 50000 cycles after UPDATE, ch2 shows exactly 33000 pulses; ch0/ch1 keep 25000 each.
- Write ch1 inc=0 → ch1 silent for 10000 cycles; ch0 unaffected in rate; realignment still occurs on all channels.
- Write ch0 phase=0xFFFF with inc=0x0001 → the first ch0 pulse appears 2 edges after UPDATE.
- `cfg_ch`=5 with `cfg_valid` high while LOCKED → accepted, `locked` stays 1, no change to any channel.
- Assert `rst_n` low during SETTLE after a write → all outputs return to 0 and inc returns to 0x8000; the full lock sequence repeats.

Source files
------------

// File: rtl/video_clk_enable_gen_if.sv
// Configuration write channel of video_clk_enable_gen: valid/ready handshake
// carrying the target channel, its new increment and its new phase offset.
interface video_clk_enable_gen_if #(
   parameter int ACC_W = 16
);
   logic             cfg_valid;
   logic             cfg_ready;
   logic [2:0]       cfg_ch;
   logic [ACC_W-1:0] cfg_inc;
   logic [ACC_W-1:0] cfg_phase;

   modport master (
      output cfg_valid,
      output cfg_ch,
      output cfg_inc,
      output cfg_phase,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid,
      input  cfg_ch,
      input  cfg_inc,
      input  cfg_phase,
      output cfg_ready
   );
endinterface

// File: rtl/video_clk_enable_gen.sv
// Multi-channel fractional clock-enable generator (phase accumulators) with a settle/lock FSM.
// Optional macro VIDEO_CLKEN_TOGGLE_EN adds clk_div, a toggle flop per channel driven by ce_out.
module video_clk_enable_gen #(
   parameter int NUM_CH      = 3,
   parameter int ACC_W       = 16,
   parameter int LOCK_CYCLES = 1024
) (
   input  logic                  refclk,
   input  logic                  rst_n,
   video_clk_enable_gen_if.slave cfg,
   output logic [NUM_CH-1:0]     ce_out,
`ifdef VIDEO_CLKEN_TOGGLE_EN
   output logic                  locked,
   output logic [NUM_CH-1:0]     clk_div
`else
   output logic                  locked
`endif
);

   localparam logic [1:0] ST_SETTLE = 2'd0;
   localparam logic [1:0] ST_LOCKED = 2'd1;
   localparam logic [1:0] ST_UPDATE = 2'd2;

   localparam int CNT_W = (LOCK_CYCLES > 2) ? $clog2(LOCK_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(LOCK_CYCLES - 1);
   localparam logic [ACC_W-1:0] INC_RESET = {1'b1, {(ACC_W-1){1'b0}}};

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic             ready;
   logic             ch_ok;
   logic             accept;
   logic             wr;
   logic             in_update;

   // Out-of-range channels still complete the handshake but never touch state.
   assign ch_ok     = ({29'd0, cfg.cfg_ch} < 32'(NUM_CH));
   assign accept    = cfg.cfg_valid && ready;
   assign wr        = accept && ch_ok;
   assign in_update = (state == ST_UPDATE);
   assign cfg.cfg_ready = ready;

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_SETTLE;
         cnt    <= '0;
         locked <= 1'b0;
         ready  <= 1'b0;
      end else begin
         case (state)
            ST_SETTLE: begin
               if (wr) begin
                  state  <= ST_UPDATE;
                  locked <= 1'b0;
                  ready  <= 1'b0;
               end else begin
                  ready <= 1'b1;
                  cnt   <= cnt + 1'b1;
                  if (cnt == CNT_LAST) begin
                     state  <= ST_LOCKED;
                     locked <= 1'b1;
                  end
               end
            end
            ST_LOCKED: begin
               if (wr) begin
                  state  <= ST_UPDATE;
                  locked <= 1'b0;
                  ready  <= 1'b0;
               end else begin
                  ready <= 1'b1;
               end
            end
            ST_UPDATE: begin
               state <= ST_SETTLE;
               cnt   <= '0;
               ready <= 1'b1;
            end
            default: begin
               state  <= ST_SETTLE;
               cnt    <= '0;
               locked <= 1'b0;
               ready  <= 1'b0;
            end
         endcase
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [ACC_W-1:0] inc_r;
      logic [ACC_W-1:0] phase_r;
      logic [ACC_W-1:0] acc_r;
      logic             ce_r;
      logic [ACC_W:0]   sum;

      // The carry out of the accumulator is the enable pulse.
      assign sum       = {1'b0, acc_r} + {1'b0, inc_r};
      assign ce_out[i] = ce_r;

      always_ff @(posedge refclk or negedge rst_n) begin
         if (!rst_n) begin
            inc_r   <= INC_RESET;
            phase_r <= '0;
            acc_r   <= '0;
            ce_r    <= 1'b0;
         end else begin
            if (wr && (cfg.cfg_ch == 3'(i))) begin
               inc_r   <= cfg.cfg_inc;
               phase_r <= cfg.cfg_phase;
            end
            if (in_update) begin
               acc_r <= phase_r;
               ce_r  <= 1'b0;
            end else begin
               acc_r <= sum[ACC_W-1:0];
               ce_r  <= sum[ACC_W];
            end
         end
      end

`ifdef VIDEO_CLKEN_TOGGLE_EN
      logic tog_r;
      assign clk_div[i] = tog_r;

      always_ff @(posedge refclk or negedge rst_n) begin
         if (!rst_n) begin
            tog_r <= 1'b0;
         end else if (in_update) begin
            tog_r <= 1'b0;
         end else if (ce_r) begin
            tog_r <= ~tog_r;
         end
      end
`endif
   end

endmodule

// File: tb/tb_video_clk_enable_gen.sv
// Directed bench for video_clk_enable_gen: reset/lock timing, fractional rates,
// realignment, phase offset, ignored channel, back-to-back writes, reset mid-settle.
module tb_video_clk_enable_gen;

   localparam int NUM_CH      = 3;
   localparam int ACC_W       = 16;
   localparam int LOCK_CYCLES = 1024;

   logic              refclk = 1'b0;
   logic              rst_n  = 1'b1;
   logic [NUM_CH-1:0] ce_out;
   logic              locked;
`ifdef VIDEO_CLKEN_TOGGLE_EN
   logic [NUM_CH-1:0] clk_div;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   always #10 refclk = ~refclk;

   video_clk_enable_gen_if #(.ACC_W(ACC_W)) cfg ();

   video_clk_enable_gen #(
      .NUM_CH(NUM_CH),
      .ACC_W(ACC_W),
      .LOCK_CYCLES(LOCK_CYCLES)
   ) dut (
      .refclk(refclk),
      .rst_n(rst_n),
      .cfg(cfg),
      .ce_out(ce_out),
`ifdef VIDEO_CLKEN_TOGGLE_EN
      .locked(locked),
      .clk_div(clk_div)
`else
      .locked(locked)
`endif
   );

   task automatic tick();
      @(posedge refclk);
      #1;
   endtask

   task automatic cfg_write(input logic [2:0] ch, input logic [15:0] inc, input logic [15:0] phase);
      cfg.cfg_valid = 1'b1;
      cfg.cfg_ch    = ch;
      cfg.cfg_inc   = inc;
      cfg.cfg_phase = phase;
      tick();
      cfg.cfg_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      cfg.cfg_valid = 1'b0;
      #3;
      n_cmp++; if (ce_out !== 3'b000) begin n_bad++; $display("FAIL reset_ce: got %b expected 000", ce_out); end
      n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL reset_locked: got %b expected 0", locked); end
      n_cmp++; if (cfg.cfg_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b expected 0", cfg.cfg_ready); end
      tick();
      tick();
      n_cmp++; if (cfg.cfg_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready_held: got %b expected 0", cfg.cfg_ready); end
      rst_n = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         tick();
         n_cmp++;
         if (ce_out !== ((k % 2 == 0) ? 3'b111 : 3'b000)) begin
            n_bad++; $display("FAIL reset_ce_pattern edge %0d: got %b expected %b", k, ce_out, (k % 2 == 0) ? 3'b111 : 3'b000);
         end
         if (k == 1) begin
            n_cmp++; if (cfg.cfg_ready !== 1'b1) begin n_bad++; $display("FAIL ready_after_release: got %b expected 1", cfg.cfg_ready); end
         end
      end
      for (int k = 9; k <= LOCK_CYCLES; k++) begin
         tick();
         if (k == LOCK_CYCLES - 1) begin
            n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL locked_early: got %b expected 0 at edge %0d", locked, k); end
         end
      end
      n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL locked_rise: got %b expected 1 at edge %0d", locked, LOCK_CYCLES); end
   endtask

   task automatic test_rate_33();
      int c0, c1, c2;
      c0 = 0; c1 = 0; c2 = 0;
      cfg_write(3'd2, 16'hA8F6, 16'h0000);
      n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL rate_locked_drop: got %b expected 0", locked); end
      n_cmp++; if (cfg.cfg_ready !== 1'b0) begin n_bad++; $display("FAIL rate_ready_update: got %b expected 0", cfg.cfg_ready); end
      tick();
      n_cmp++; if (ce_out !== 3'b000) begin n_bad++; $display("FAIL rate_update_ce: got %b expected 000", ce_out); end
      n_cmp++; if (cfg.cfg_ready !== 1'b1) begin n_bad++; $display("FAIL rate_ready_after: got %b expected 1", cfg.cfg_ready); end
      for (int k = 0; k < 50000; k++) begin
         tick();
         c0 += int'(ce_out[0]);
         c1 += int'(ce_out[1]);
         c2 += int'(ce_out[2]);
      end
      n_cmp++; if (c2 !== 33000) begin n_bad++; $display("FAIL rate_ch2_count: got %0d expected 33000", c2); end
      n_cmp++; if (c0 !== 25000) begin n_bad++; $display("FAIL rate_ch0_count: got %0d expected 25000", c0); end
      n_cmp++; if (c1 !== 25000) begin n_bad++; $display("FAIL rate_ch1_count: got %0d expected 25000", c1); end
      n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL rate_relock: got %b expected 1", locked); end
   endtask

   task automatic test_inc_zero();
      int c0, c1;
      c0 = 0; c1 = 0;
      cfg_write(3'd1, 16'h0000, 16'h0000);
      tick();
      n_cmp++; if (ce_out !== 3'b000) begin n_bad++; $display("FAIL zero_update_ce: got %b expected 000", ce_out); end
      for (int k = 2; k <= 10001; k++) begin
         tick();
         c0 += int'(ce_out[0]);
         c1 += int'(ce_out[1]);
         if (k == 2) begin
            n_cmp++; if (ce_out !== 3'b000) begin n_bad++; $display("FAIL zero_realign_e2: got %b expected 000", ce_out); end
         end
         if (k == 3) begin
            n_cmp++; if (ce_out !== 3'b101) begin n_bad++; $display("FAIL zero_realign_e3: got %b expected 101", ce_out); end
         end
      end
      n_cmp++; if (c1 !== 0) begin n_bad++; $display("FAIL zero_ch1_count: got %0d expected 0", c1); end
      n_cmp++; if (c0 !== 5000) begin n_bad++; $display("FAIL zero_ch0_count: got %0d expected 5000", c0); end
   endtask

   task automatic test_phase();
      bit got_lock;
      cfg_write(3'd0, 16'h0001, 16'hFFFF);
      tick();
      n_cmp++; if (ce_out !== 3'b000) begin n_bad++; $display("FAIL phase_update_ce: got %b expected 000", ce_out); end
      tick();
      n_cmp++; if (ce_out !== 3'b001) begin n_bad++; $display("FAIL phase_first_pulse: got %b expected 001", ce_out); end
      tick();
      n_cmp++; if (ce_out !== 3'b100) begin n_bad++; $display("FAIL phase_next: got %b expected 100", ce_out); end
      got_lock = 1'b0;
      for (int k = 0; k < 2000 && !got_lock; k++) begin
         tick();
         if (locked === 1'b1) got_lock = 1'b1;
      end
      n_cmp++; if (got_lock !== 1'b1) begin n_bad++; $display("FAIL phase_relock_timeout: got %b expected 1", got_lock); end
   endtask

   task automatic test_bad_ch();
      int c1;
      c1 = 0;
      n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL badch_pre_locked: got %b expected 1", locked); end
      cfg_write(3'd5, 16'h8000, 16'h1234);
      n_cmp++; if (cfg.cfg_ready !== 1'b1) begin n_bad++; $display("FAIL badch_ready: got %b expected 1", cfg.cfg_ready); end
      n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL badch_locked: got %b expected 1", locked); end
      for (int k = 0; k < 200; k++) begin
         tick();
         c1 += int'(ce_out[1]);
      end
      n_cmp++; if (c1 !== 0) begin n_bad++; $display("FAIL badch_ch1_count: got %0d expected 0", c1); end
      n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL badch_locked_after: got %b expected 1", locked); end
   endtask

   task automatic test_back_to_back();
      cfg.cfg_valid = 1'b1;
      cfg.cfg_ch    = 3'd0;
      cfg.cfg_inc   = 16'h8000;
      cfg.cfg_phase = 16'h0000;
      tick();
      n_cmp++; if (cfg.cfg_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_ready_e0: got %b expected 0", cfg.cfg_ready); end
      n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL b2b_locked_e0: got %b expected 0", locked); end
      tick();
      n_cmp++; if (cfg.cfg_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_e1: got %b expected 1", cfg.cfg_ready); end
      tick();
      n_cmp++; if (cfg.cfg_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_ready_e2: got %b expected 0", cfg.cfg_ready); end
      cfg.cfg_valid = 1'b0;
      tick();
      n_cmp++; if (cfg.cfg_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_e3: got %b expected 1", cfg.cfg_ready); end
      n_cmp++; if (ce_out !== 3'b000) begin n_bad++; $display("FAIL b2b_update_ce: got %b expected 000", ce_out); end
      tick();
      tick();
      n_cmp++; if (ce_out !== 3'b101) begin n_bad++; $display("FAIL b2b_settle_ce: got %b expected 101", ce_out); end
   endtask

   initial begin
      cfg.cfg_valid = 1'b0;
      cfg.cfg_ch    = 3'd0;
      cfg.cfg_inc   = '0;
      cfg.cfg_phase = '0;
      test_reset();
      test_rate_33();
      test_inc_zero();
      test_phase();
      test_bad_ch();
      test_back_to_back();
      test_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
